// File: rtl/mem_access_unit.sv
// LC-3b memory-stage access controller: sequences loads, stores, indirect and TRAP fetches over dmem.
// Optional MEM_ALIGN_CHECK_EN adds align_err and rejects odd word addresses instead of clearing bit 0.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [2:0]  mem_op,
  input  logic [15:0] addr_in,
  input  logic [15:0] store_data_in,
  input  logic [2:0]  dest_in,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_mem_data,
  output logic [15:0] wb_alu_out,
  output logic [2:0]  wb_dest
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  typedef enum logic [1:0] {IDLE, IND_ADDR, ACCESS, DONE} state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;

  function automatic logic is_word(input logic [2:0] op);
    return (op != OP_LDB) && (op != OP_STB);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  function automatic logic is_ind(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  dest_q, dest_d;
  logic [15:0] wb_mem_data_q, wb_mem_data_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err_q, align_err_d;
`endif

  logic        req;
  logic [15:0] eff_addr;

  assign req      = valid_in && (mem_op != OP_NONE);
  assign eff_addr = is_word(op_q) ? {addr_q[15:1], 1'b0} : addr_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    dest_d        = dest_q;
    wb_mem_data_d = wb_mem_data_q;
`ifdef MEM_ALIGN_CHECK_EN
    align_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = mem_op;
          addr_d  = addr_in;
          data_d  = store_data_in;
          dest_d  = dest_in;
          state_d = is_ind(mem_op) ? IND_ADDR : ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          if (is_word(mem_op) && addr_in[0]) begin
            state_d     = DONE;
            align_err_d = 1'b1;
          end
`endif
        end
      end
      IND_ADDR: begin
        if (dmem_resp) begin
          addr_d  = dmem_rdata;
          state_d = ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          if (dmem_rdata[0]) begin
            state_d     = DONE;
            align_err_d = 1'b1;
          end
`endif
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          if (!is_store(op_q)) wb_mem_data_d = dmem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_q          <= OP_NONE;
      addr_q        <= 16'h0000;
      data_q        <= 16'h0000;
      dest_q        <= 3'd0;
      wb_mem_data_q <= 16'h0000;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      dest_q        <= dest_d;
      wb_mem_data_q <= wb_mem_data_d;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q   <= align_err_d;
`endif
    end
  end

  // Bus outputs are pure decodes of the latched request, so they stay put while memory waits.
  always_comb begin
    dmem_read  = (state_q == IND_ADDR) || ((state_q == ACCESS) && !is_store(op_q));
    dmem_write = (state_q == ACCESS) && is_store(op_q);
    if (dmem_write && !is_word(op_q))
      dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
    else if (dmem_read || dmem_write)
      dmem_byte_enable = 2'b11;
    else
      dmem_byte_enable = 2'b00;
  end

  assign dmem_address = eff_addr;
  assign dmem_wdata   = is_word(op_q) ? data_q : {data_q[7:0], data_q[7:0]};
  assign stall        = ((state_q == IDLE) && req) || (state_q == IND_ADDR) || (state_q == ACCESS);
  assign wb_valid     = (state_q == DONE);
  assign wb_mem_data  = wb_mem_data_q;
  assign wb_alu_out   = eff_addr;
  assign wb_dest      = dest_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err    = align_err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single-wait transactions
// plus hand-written sequences for wait states, async reset and address bit 0 handling.
module tb_mem_access_unit;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDR  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;
  localparam logic [2:0] OP_TRAP = 3'd7;

  logic        clk;
  logic        reset_n;
  logic        valid_in;
  logic [2:0]  mem_op;
  logic [15:0] addr_in;
  logic [15:0] store_data_in;
  logic [2:0]  dest_in;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_mem_data;
  logic [15:0] wb_alu_out;
  logic [2:0]  wb_dest;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .mem_op           (mem_op),
    .addr_in          (addr_in),
    .store_data_in    (store_data_in),
    .dest_in          (dest_in),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .stall            (stall),
    .wb_valid         (wb_valid),
    .wb_mem_data      (wb_mem_data),
    .wb_alu_out       (wb_alu_out),
    .wb_dest          (wb_dest)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_err        (align_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] sdata;
    logic [2:0]  dest;
    logic [15:0] ptr;
    logic [15:0] rdata;
    logic [15:0] exp_addr1;
    logic [15:0] exp_addr2;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata;
    logic [15:0] exp_wb_data;
    logic [15:0] exp_alu;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [15:0] a,
                               input logic [15:0] sd, input logic [2:0] d,
                               input logic r, input logic [15:0] rd);
    valid_in      = v;
    mem_op        = op;
    addr_in       = a;
    store_data_in = sd;
    dest_in       = d;
    dmem_resp     = r;
    dmem_rdata    = rd;
  endtask

  // Memory answers in the first cycle of each access; valid_in stays high through DONE.
  task automatic runVector(input vec_t v);
    logic ind, st;
    ind = (v.op == OP_LDI) || (v.op == OP_STI);
    st  = (v.op == OP_STR) || (v.op == OP_STB) || (v.op == OP_STI);
    @(negedge clk);
    applyStimulus(1'b1, v.op, v.addr, v.sdata, v.dest, 1'b0, 16'h0000);
    #1;
    checkOutput("req_stall", 16'(stall), 16'h1);
    checkOutput("req_no_read", 16'(dmem_read), 16'h0);
    if (ind) begin
      @(negedge clk);
      applyStimulus(1'b1, v.op, v.addr, v.sdata, v.dest, 1'b1, v.ptr);
      #1;
      checkOutput("ind_read", 16'(dmem_read), 16'h1);
      checkOutput("ind_write", 16'(dmem_write), 16'h0);
      checkOutput("ind_addr", dmem_address, v.exp_addr1);
      checkOutput("ind_be", 16'(dmem_byte_enable), 16'h3);
      checkOutput("ind_stall", 16'(stall), 16'h1);
    end
    @(negedge clk);
    applyStimulus(1'b1, v.op, v.addr, v.sdata, v.dest, 1'b1, v.rdata);
    #1;
    checkOutput("acc_read", 16'(dmem_read), 16'(!st));
    checkOutput("acc_write", 16'(dmem_write), 16'(st));
    checkOutput("acc_addr", dmem_address, v.exp_addr2);
    checkOutput("acc_be", 16'(dmem_byte_enable), 16'(v.exp_be));
    if (st) checkOutput("acc_wdata", dmem_wdata, v.exp_wdata);
    checkOutput("acc_stall", 16'(stall), 16'h1);
    @(negedge clk);
    applyStimulus(1'b1, v.op, v.addr, v.sdata, v.dest, 1'b0, 16'h0000);
    #1;
    checkOutput("done_wb_valid", 16'(wb_valid), 16'h1);
    checkOutput("done_wb_data", wb_mem_data, v.exp_wb_data);
    checkOutput("done_wb_alu", wb_alu_out, v.exp_alu);
    checkOutput("done_wb_dest", 16'(wb_dest), 16'(v.dest));
    checkOutput("done_stall", 16'(stall), 16'h0);
    checkOutput("done_no_req", 16'({dmem_read, dmem_write}), 16'h0);
    checkOutput("done_be", 16'(dmem_byte_enable), 16'h0);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    #1;
    checkOutput("idle_wb_valid", 16'(wb_valid), 16'h0);
    checkOutput("idle_stall", 16'(stall), 16'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stall_cnt;
    int wb_cnt;

    vecs[0] = '{OP_LDR,  16'h3000, 16'h0000, 3'd1, 16'h0000, 16'hBEEF, 16'h0000, 16'h3000, 2'b11, 16'h0000, 16'hBEEF, 16'h3000};
    vecs[1] = '{OP_STB,  16'h2001, 16'h12AB, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h2001, 2'b10, 16'hABAB, 16'hBEEF, 16'h2001};
    vecs[2] = '{OP_LDI,  16'h4000, 16'h0000, 3'd3, 16'h5000, 16'h7777, 16'h4000, 16'h5000, 2'b11, 16'h0000, 16'h7777, 16'h5000};
    vecs[3] = '{OP_STR,  16'h3002, 16'h5A5A, 3'd5, 16'h0000, 16'h0000, 16'h0000, 16'h3002, 2'b11, 16'h5A5A, 16'h7777, 16'h3002};
    vecs[4] = '{OP_LDB,  16'h1235, 16'h0000, 3'd4, 16'h0000, 16'hC3D4, 16'h0000, 16'h1235, 2'b11, 16'h0000, 16'hC3D4, 16'h1235};
    vecs[5] = '{OP_STB,  16'h2000, 16'h00FF, 3'd6, 16'h0000, 16'h0000, 16'h0000, 16'h2000, 2'b01, 16'hFFFF, 16'hC3D4, 16'h2000};
    vecs[6] = '{OP_TRAP, 16'h0046, 16'h0000, 3'd7, 16'h0000, 16'h1A00, 16'h0000, 16'h0046, 2'b11, 16'h0000, 16'h1A00, 16'h0046};
    vecs[7] = '{OP_STI,  16'h6000, 16'hCAFE, 3'd0, 16'h6100, 16'h0000, 16'h6000, 16'h6100, 2'b11, 16'hCAFE, 16'h1A00, 16'h6100};

    // Reset values
    reset_n = 1'b0;
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    #1;
    checkOutput("rst_read", 16'(dmem_read), 16'h0);
    checkOutput("rst_write", 16'(dmem_write), 16'h0);
    checkOutput("rst_addr", dmem_address, 16'h0000);
    checkOutput("rst_wdata", dmem_wdata, 16'h0000);
    checkOutput("rst_be", 16'(dmem_byte_enable), 16'h0);
    checkOutput("rst_stall", 16'(stall), 16'h0);
    checkOutput("rst_wb_valid", 16'(wb_valid), 16'h0);
    checkOutput("rst_wb_data", wb_mem_data, 16'h0000);
    checkOutput("rst_wb_alu", wb_alu_out, 16'h0000);
    checkOutput("rst_wb_dest", 16'(wb_dest), 16'h0);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("rst_align_err", 16'(align_err), 16'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    // LDR with four memory wait cycles
    stall_cnt = 0;
    wb_cnt    = 0;
    @(negedge clk);
    applyStimulus(1'b1, OP_LDR, 16'h0800, 16'h0000, 3'd2, 1'b0, 16'h0000);
    #1;
    if (stall) stall_cnt++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, OP_LDR, 16'h0800, 16'h0000, 3'd2, (k == 4), (k == 4) ? 16'h1357 : 16'hDEAD);
      #1;
      if (stall) stall_cnt++;
      checkOutput("dly_read", 16'(dmem_read), 16'h1);
      checkOutput("dly_addr", dmem_address, 16'h0800);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
      #1;
      if (stall) stall_cnt++;
      if (wb_valid) wb_cnt++;
      if (k == 0) checkOutput("dly_wb_data", wb_mem_data, 16'h1357);
    end
    checkOutput("dly_stall_cycles", 16'(stall_cnt), 16'd5);
    checkOutput("dly_wb_pulses", 16'(wb_cnt), 16'd1);

    // Asynchronous reset while ACCESS is pending
    @(negedge clk);
    applyStimulus(1'b1, OP_LDR, 16'h0900, 16'h0000, 3'd3, 1'b0, 16'h0000);
    @(negedge clk);
    #1;
    checkOutput("rstacc_read_before", 16'(dmem_read), 16'h1);
    #1;
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    reset_n = 1'b0;
    #1;
    checkOutput("rstacc_read_drop", 16'(dmem_read), 16'h0);
    checkOutput("rstacc_write", 16'(dmem_write), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wb_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (wb_valid) wb_cnt++;
    end
    checkOutput("rstacc_no_wb", 16'(wb_cnt), 16'd0);
    checkOutput("rstacc_idle_read", 16'(dmem_read), 16'h0);
    checkOutput("rstacc_idle_addr", dmem_address, 16'h0000);

    // dmem_resp in IDLE and valid_in with NONE are ignored
    @(negedge clk);
    applyStimulus(1'b1, OP_NONE, 16'h1111, 16'h0000, 3'd1, 1'b1, 16'hFFFF);
    #1;
    checkOutput("none_stall", 16'(stall), 16'h0);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    #1;
    checkOutput("idle_resp_wb_valid", 16'(wb_valid), 16'h0);
    checkOutput("idle_resp_wb_data", wb_mem_data, 16'h0000);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned STR is rejected straight to DONE
    @(negedge clk);
    applyStimulus(1'b1, OP_STR, 16'h3001, 16'h4242, 3'd1, 1'b0, 16'h0000);
    #1;
    checkOutput("al_str_stall", 16'(stall), 16'h1);
    @(negedge clk);
    #1;
    checkOutput("al_str_wb_valid", 16'(wb_valid), 16'h1);
    checkOutput("al_str_align_err", 16'(align_err), 16'h1);
    checkOutput("al_str_no_write", 16'(dmem_write), 16'h0);
    checkOutput("al_str_stall_done", 16'(stall), 16'h0);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    #1;
    checkOutput("al_str_err_clear", 16'(align_err), 16'h0);
    // LDI with an odd pointer
    @(negedge clk);
    applyStimulus(1'b1, OP_LDI, 16'h4000, 16'h0000, 3'd2, 1'b0, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b1, OP_LDI, 16'h4000, 16'h0000, 3'd2, 1'b1, 16'h5001);
    #1;
    checkOutput("al_ldi_ptr_read", dmem_address, 16'h4000);
    @(negedge clk);
    applyStimulus(1'b1, OP_LDI, 16'h4000, 16'h0000, 3'd2, 1'b0, 16'h0000);
    #1;
    checkOutput("al_ldi_wb_valid", 16'(wb_valid), 16'h1);
    checkOutput("al_ldi_align_err", 16'(align_err), 16'h1);
    checkOutput("al_ldi_no_read", 16'(dmem_read), 16'h0);
    checkOutput("al_ldi_wb_data", wb_mem_data, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
`else
    // Odd word addresses have bit 0 cleared, including the indirect pointer
    @(negedge clk);
    applyStimulus(1'b1, OP_STR, 16'h3001, 16'h4242, 3'd1, 1'b0, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b1, OP_STR, 16'h3001, 16'h4242, 3'd1, 1'b1, 16'h0000);
    #1;
    checkOutput("odd_str_write", 16'(dmem_write), 16'h1);
    checkOutput("odd_str_addr", dmem_address, 16'h3000);
    checkOutput("odd_str_wdata", dmem_wdata, 16'h4242);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    #1;
    checkOutput("odd_str_wb_alu", wb_alu_out, 16'h3000);
    checkOutput("odd_str_wb_data", wb_mem_data, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b1, OP_LDI, 16'h4001, 16'h0000, 3'd6, 1'b0, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b1, OP_LDI, 16'h4001, 16'h0000, 3'd6, 1'b1, 16'h5001);
    #1;
    checkOutput("odd_ldi_ptr_addr", dmem_address, 16'h4000);
    @(negedge clk);
    applyStimulus(1'b1, OP_LDI, 16'h4001, 16'h0000, 3'd6, 1'b1, 16'h0101);
    #1;
    checkOutput("odd_ldi_final_addr", dmem_address, 16'h5000);
    @(negedge clk);
    applyStimulus(1'b0, OP_NONE, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000);
    #1;
    checkOutput("odd_ldi_wb_valid", 16'(wb_valid), 16'h1);
    checkOutput("odd_ldi_wb_data", wb_mem_data, 16'h0101);
    checkOutput("odd_ldi_wb_alu", wb_alu_out, 16'h5000);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
